// File: rtl/peri_pdm_decimator.sv
// peri_pdm_decimator: 3rd-order CIC PDM-to-PCM decimator with a sample FIFO,
// drained over an 8-bit zero-wait-state Wishbone B4 slave port.
// Optional build macro PERI_PDM_DECIMATOR_DC_BLOCK_EN inserts a DC-removal
// high-pass filter between saturation and the FIFO (adds one cycle of latency).
module peri_pdm_decimator #(
    parameter int unsigned DecimR    = 64,
    parameter int unsigned AudioBits = 16,
    parameter int unsigned FifoDepth = 8
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wb_we_i,
    input  logic       wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       pdm_valid_i,
    input  logic       pdm_data_i,
    output logic       irq_o
);

    localparam int unsigned DecBits  = $clog2(DecimR);
    localparam int unsigned W        = 3 * DecBits + 2;
    localparam int unsigned AddrBits = $clog2(FifoDepth);
    localparam int unsigned CntBits  = AddrBits + 1;
    localparam int unsigned WX       = W + AudioBits;
    localparam int unsigned Shr      = (W - 1 > AudioBits) ? (W - 1 - AudioBits) : 0;
    localparam int unsigned Shl      = (AudioBits > W - 1) ? (AudioBits - (W - 1)) : 0;

    // Scale the comb output to AudioBits and clamp to the signed range.
    function automatic logic [AudioBits-1:0] scale_sat(input logic [W-1:0] v);
        logic signed [WX-1:0] ext;
        logic signed [WX-1:0] scaled;
        ext    = $signed({{AudioBits{v[W-1]}}, v});
        scaled = (ext >>> Shr) <<< Shl;
        if (scaled[WX-1:AudioBits-1] == {(WX - AudioBits + 1){scaled[WX-1]}}) begin
            return scaled[AudioBits-1:0];
        end else if (scaled[WX-1]) begin
            return {1'b1, {(AudioBits - 1){1'b0}}};
        end else begin
            return {1'b0, {(AudioBits - 1){1'b1}}};
        end
    endfunction

    // Control / status registers
    logic enable_q, enable_d;
    logic irq_en_q, irq_en_d;
    logic overflow_q, overflow_d;
    logic byte_ptr_q, byte_ptr_d;
    logic irq_q, irq_d;

    // CIC state
    logic [W-1:0]       i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic [W-1:0]       c1_dly_q, c1_dly_d, c2_dly_q, c2_dly_d, c3_dly_q, c3_dly_d;
    logic [W-1:0]       c3_q, c3_d;
    logic [DecBits-1:0] dec_cnt_q, dec_cnt_d;
    logic [1:0]         warm_q, warm_d;
    logic               cand_valid_q, cand_valid_d;

    // FIFO state
    logic [AudioBits-1:0] mem_q [FifoDepth];
    logic [AudioBits-1:0] mem_d [FifoDepth];
    logic [AddrBits-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntBits-1:0]   count_q, count_d;

    // Decoded strobes and datapath intermediates
    logic                 ctrl_wr_c, data_rd_c, clear_c, cic_zero_c, upd_c, wrap_c;
    logic                 pop_c, push_ok_c, full_c, push_req_c;
    logic [W-1:0]         x_c, comb1_c, comb2_c, comb3_c;
    logic [AudioBits-1:0] head_c, push_data_c;
    logic [3:0]           cnt4_c;
    logic                 unused_dat_c;

    assign unused_dat_c = ^wb_dat_i[7:3];
    assign wb_ack_o     = wb_stb_i;
    assign irq_o        = irq_q;

    // Bus decode and CIC input mapping (+1 / -1)
    always_comb begin
        ctrl_wr_c  = wb_stb_i && wb_we_i && !wb_adr_i;
        data_rd_c  = wb_stb_i && !wb_we_i && wb_adr_i;
        clear_c    = ctrl_wr_c && wb_dat_i[0];
        cic_zero_c = clear_c || !enable_q;
        upd_c      = pdm_valid_i && enable_q;
        wrap_c     = upd_c && (dec_cnt_q == DecBits'(DecimR - 1));
        x_c        = pdm_data_i ? W'(1) : {W{1'b1}};
    end

    // Integrators, decimation counter, comb stages and warm-up gating
    always_comb begin
        i1_d         = i1_q;
        i2_d         = i2_q;
        i3_d         = i3_q;
        c1_dly_d     = c1_dly_q;
        c2_dly_d     = c2_dly_q;
        c3_dly_d     = c3_dly_q;
        c3_d         = c3_q;
        dec_cnt_d    = dec_cnt_q;
        warm_d       = warm_q;
        cand_valid_d = 1'b0;
        comb1_c      = (i3_q + i2_q) - c1_dly_q;
        comb2_c      = comb1_c - c2_dly_q;
        comb3_c      = comb2_c - c3_dly_q;
        if (cic_zero_c) begin
            i1_d      = '0;
            i2_d      = '0;
            i3_d      = '0;
            c1_dly_d  = '0;
            c2_dly_d  = '0;
            c3_dly_d  = '0;
            c3_d      = '0;
            dec_cnt_d = '0;
            warm_d    = '0;
        end else if (upd_c) begin
            i1_d      = i1_q + x_c;
            i2_d      = i2_q + i1_q;
            i3_d      = i3_q + i2_q;
            dec_cnt_d = dec_cnt_q + DecBits'(1);
            if (wrap_c) begin
                c1_dly_d     = i3_q + i2_q;
                c2_dly_d     = comb1_c;
                c3_dly_d     = comb2_c;
                c3_d         = comb3_c;
                cand_valid_d = (warm_q == 2'd3);
                warm_d       = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
            end
        end
    end

`ifdef PERI_PDM_DECIMATOR_DC_BLOCK_EN
    localparam int unsigned DcBits = AudioBits + 8;

    logic [AudioBits-1:0]     dc_x_q, dc_x_d;
    logic [DcBits-1:0]        dc_y_q, dc_y_d;
    logic                     dc_valid_q, dc_valid_d;
    logic [AudioBits-1:0]     dc_in_c;
    logic signed [DcBits-1:0] dc_ys_c;

    // DC-removal high-pass: y = x - x_prev + y_prev - (y_prev >>> 8)
    always_comb begin
        dc_x_d     = dc_x_q;
        dc_y_d     = dc_y_q;
        dc_valid_d = 1'b0;
        dc_in_c    = scale_sat(c3_q);
        dc_ys_c    = $signed(dc_y_q);
        if (cic_zero_c) begin
            dc_x_d = '0;
            dc_y_d = '0;
        end else if (cand_valid_q) begin
            dc_valid_d = 1'b1;
            dc_x_d     = dc_in_c;
            dc_y_d     = {{8{dc_in_c[AudioBits-1]}}, dc_in_c}
                       - {{8{dc_x_q[AudioBits-1]}}, dc_x_q}
                       + dc_y_q - DcBits'(dc_ys_c >>> 8);
        end
    end

    // Filter output saturation feeds the FIFO
    always_comb begin
        push_req_c = dc_valid_q;
        if (dc_y_q[DcBits-1:AudioBits-1] == {(DcBits - AudioBits + 1){dc_y_q[DcBits-1]}}) begin
            push_data_c = dc_y_q[AudioBits-1:0];
        end else if (dc_y_q[DcBits-1]) begin
            push_data_c = {1'b1, {(AudioBits - 1){1'b0}}};
        end else begin
            push_data_c = {1'b0, {(AudioBits - 1){1'b1}}};
        end
    end

    // DC filter state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            dc_x_q     <= '0;
            dc_y_q     <= '0;
            dc_valid_q <= 1'b0;
        end else begin
            dc_x_q     <= dc_x_d;
            dc_y_q     <= dc_y_d;
            dc_valid_q <= dc_valid_d;
        end
    end
`else
    // Saturated CIC output feeds the FIFO directly
    always_comb begin
        push_req_c  = cand_valid_q;
        push_data_c = scale_sat(c3_q);
    end
`endif

    // FIFO push/pop, byte pointer, control writes and interrupt level
    always_comb begin
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        overflow_d = overflow_q;
        byte_ptr_d = byte_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        mem_d      = mem_q;
        head_c     = mem_q[rd_ptr_q];
        full_c     = (count_q == CntBits'(FifoDepth));
        pop_c      = data_rd_c && (count_q != '0) && byte_ptr_q;
        push_ok_c  = push_req_c && (!full_c || pop_c);
        irq_d      = irq_en_q && (count_q != '0);
        if (ctrl_wr_c) begin
            enable_d = wb_dat_i[1];
            irq_en_d = wb_dat_i[2];
        end
        if (clear_c) begin
            overflow_d = 1'b0;
            byte_ptr_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (data_rd_c && (count_q != '0)) begin
                byte_ptr_d = !byte_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + AddrBits'(1);
            end
            if (push_ok_c) begin
                mem_d[wr_ptr_q] = push_data_c;
                wr_ptr_d        = wr_ptr_q + AddrBits'(1);
            end else if (push_req_c) begin
                overflow_d = 1'b1;
            end
            count_d = count_q + CntBits'(push_ok_c) - CntBits'(pop_c);
        end
    end

    // Read data mux: STATUS or the selected byte of the FIFO head
    always_comb begin
        cnt4_c = (32'(count_q) > 32'd15) ? 4'hF : 4'(count_q);
        if (wb_adr_i) begin
            if (count_q == '0) begin
                wb_dat_o = 8'h00;
            end else if (byte_ptr_q) begin
                wb_dat_o = 8'(head_c >> 8);
            end else begin
                wb_dat_o = head_c[7:0];
            end
        end else begin
            wb_dat_o = {overflow_q, irq_en_q, enable_q, byte_ptr_q, cnt4_c};
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            enable_q     <= 1'b0;
            irq_en_q     <= 1'b0;
            overflow_q   <= 1'b0;
            byte_ptr_q   <= 1'b0;
            irq_q        <= 1'b0;
            i1_q         <= '0;
            i2_q         <= '0;
            i3_q         <= '0;
            c1_dly_q     <= '0;
            c2_dly_q     <= '0;
            c3_dly_q     <= '0;
            c3_q         <= '0;
            dec_cnt_q    <= '0;
            warm_q       <= '0;
            cand_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < int'(FifoDepth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            enable_q     <= enable_d;
            irq_en_q     <= irq_en_d;
            overflow_q   <= overflow_d;
            byte_ptr_q   <= byte_ptr_d;
            irq_q        <= irq_d;
            i1_q         <= i1_d;
            i2_q         <= i2_d;
            i3_q         <= i3_d;
            c1_dly_q     <= c1_dly_d;
            c2_dly_q     <= c2_dly_d;
            c3_dly_q     <= c3_dly_d;
            c3_q         <= c3_d;
            dec_cnt_q    <= dec_cnt_d;
            warm_q       <= warm_d;
            cand_valid_q <= cand_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_peri_pdm_decimator.sv
// Directed self-checking bench for peri_pdm_decimator (default build).
module tb_peri_pdm_decimator;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       wb_we_i;
    logic       wb_adr_i;
    logic [7:0] wb_dat_i;
    logic       wb_stb_i;
    logic [7:0] wb_dat_o;
    logic       wb_ack_o;
    logic       pdm_valid_i;
    logic       pdm_data_i;
    logic       irq_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  d8;
    logic [15:0] s16;

    peri_pdm_decimator dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .wb_we_i     (wb_we_i),
        .wb_adr_i    (wb_adr_i),
        .wb_dat_i    (wb_dat_i),
        .wb_stb_i    (wb_stb_i),
        .wb_dat_o    (wb_dat_o),
        .wb_ack_o    (wb_ack_o),
        .pdm_valid_i (pdm_valid_i),
        .pdm_data_i  (pdm_data_i),
        .irq_o       (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wb_wr(input logic adr, input logic [7:0] dat);
        wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = adr; wb_dat_i = dat;
        tick();
        wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_dat_i = 8'h00;
    endtask

    task automatic wb_rd(input logic adr, output logic [7:0] dat);
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
        #1;
        dat = wb_dat_o;
        tick();
        wb_stb_i = 1'b0;
    endtask

    task automatic peek(output logic [7:0] dat);
        wb_stb_i = 1'b0; wb_adr_i = 1'b0;
        #1;
        dat = wb_dat_o;
    endtask

    task automatic rd_sample(output logic [15:0] s);
        logic [7:0] lo, hi;
        wb_rd(1'b1, lo);
        wb_rd(1'b1, hi);
        s = {hi, lo};
    endtask

    task automatic pdm_bit(input logic b);
        pdm_valid_i = 1'b1; pdm_data_i = b;
        tick();
        pdm_valid_i = 1'b0; pdm_data_i = 1'b0;
    endtask

    // mode 0: all ones, 1: all zeros, 2: alternating 1,0; one bit every 4 cycles
    task automatic stream(input int mode, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            pdm_bit(mode == 0 ? 1'b1 : (mode == 1 ? 1'b0 : ((i % 2) == 0)));
            tick(); tick(); tick();
        end
    endtask

    initial begin
        rst_ni = 1'b0; wb_we_i = 1'b0; wb_adr_i = 1'b0; wb_dat_i = 8'h00;
        wb_stb_i = 1'b0; pdm_valid_i = 1'b0; pdm_data_i = 1'b0;
        tick(); tick();
        peek(d8);        chk("rst_status", 16'(d8), 16'h0000);
        chk("rst_irq", 16'(irq_o), 16'h0000);
        rst_ni = 1'b1;
        tick();

        // Enable with interrupts, stream ones: 8 candidates, 3 discarded, 5 queued
        wb_wr(1'b0, 8'h06);
        peek(d8);        chk("en_status", 16'(d8), 16'h0060);
        stream(0, 512);
        peek(d8);        chk("ones_status", 16'(d8), 16'h0065);
        chk("ones_irq", 16'(irq_o), 16'h0001);
        wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 1'b0;
        #1;
        chk("ack_high", 16'(wb_ack_o), 16'h0001);
        chk("status_rd", 16'(wb_dat_o), 16'h0065);
        tick();
        wb_stb_i = 1'b0;
        #1;
        chk("ack_low", 16'(wb_ack_o), 16'h0000);
        wb_rd(1'b1, d8); chk("ones_lo", 16'(d8), 16'h00FF);
        peek(d8);        chk("bptr_set", 16'(d8), 16'h0075);
        wb_rd(1'b1, d8); chk("ones_hi", 16'(d8), 16'h007F);
        peek(d8);        chk("pop_status", 16'(d8), 16'h0064);
        for (int k = 0; k < 4; k++) begin
            rd_sample(s16); chk("ones_drain", s16, 16'h7FFF);
        end
        peek(d8);        chk("drained", 16'(d8), 16'h0060);
        tick(); tick();
        chk("irq_clr", 16'(irq_o), 16'h0000);
        wb_rd(1'b1, d8); chk("empty_rd", 16'(d8), 16'h0000);
        peek(d8);        chk("empty_bptr", 16'(d8), 16'h0060);

        // All zeros -> negative full scale
        wb_wr(1'b0, 8'h07);
        stream(1, 512);
        peek(d8);        chk("zeros_status", 16'(d8), 16'h0065);
        rd_sample(s16);  chk("zeros_sample", s16, 16'h8000);

        // Alternating 1,0 -> zero
        wb_wr(1'b0, 8'h07);
        peek(d8);        chk("clr_cnt", 16'(d8), 16'h0060);
        stream(2, 512);
        peek(d8);        chk("alt_status", 16'(d8), 16'h0065);
        rd_sample(s16);  chk("alt_sample", s16, 16'h0000);

        // 9 post-warm-up samples: 8 full-scale then a transition value that must be dropped
        wb_wr(1'b0, 8'h07);
        stream(0, 704);
        stream(1, 64);
        peek(d8);        chk("ovf_status", 16'(d8), 16'h00E8);
        for (int k = 0; k < 8; k++) begin
            rd_sample(s16); chk("ovf_order", s16, 16'h7FFF);
        end
        peek(d8);        chk("ovf_sticky", 16'(d8), 16'h00E0);
        wb_wr(1'b0, 8'h07);
        peek(d8);        chk("ovf_cleared", 16'(d8), 16'h0060);

        // Full FIFO: high-byte read in the same cycle as a push
        stream(0, 704);
        peek(d8);        chk("full_status", 16'(d8), 16'h0068);
        wb_rd(1'b1, d8); chk("full_lo", 16'(d8), 16'h00FF);
        stream(0, 63);
        pdm_bit(1'b1);
        wb_rd(1'b1, d8); chk("coinc_hi", 16'(d8), 16'h007F);
        peek(d8);        chk("coinc_status", 16'(d8), 16'h0068);
        rd_sample(s16);  chk("coinc_next", s16, 16'h7FFF);
        peek(d8);        chk("coinc_after", 16'(d8), 16'h0067);

        // Clear mid-period: FIFO emptied, counters restart, 3 outputs discarded, latency 2
        stream(0, 32);
        wb_wr(1'b0, 8'h07);
        peek(d8);        chk("midclr_status", 16'(d8), 16'h0060);
        stream(0, 192);
        peek(d8);        chk("midclr_warm", 16'(d8), 16'h0060);
        stream(0, 63);
        pdm_bit(1'b1);
        peek(d8);        chk("lat_before", 16'(d8), 16'h0060);
        tick();
        peek(d8);        chk("lat_after", 16'(d8), 16'h0061);

        // Reset mid-operation with byte_ptr=1 and 5 queued
        tick(); tick();
        stream(0, 256);
        peek(d8);        chk("pre_rst", 16'(d8), 16'h0065);
        wb_rd(1'b1, d8);
        peek(d8);        chk("pre_rst_bptr", 16'(d8), 16'h0075);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        peek(d8);        chk("post_rst", 16'(d8), 16'h0000);
        chk("post_rst_irq", 16'(irq_o), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
